trade_report_tx: RTL

- Transmit-side counterpart to the market-data receive path.
- Accepts trade events from the order book engine (trade_valid/trade_info) in the engine clock domain.
- Buffers them and batches them into UDP payload frames.
- Frames are emitted as an 8-bit AXI-Stream toward the UDP TX stack. Each frame carries a sequence number, a trade count and big-endian 32-bit trade words.

---
 rtl/trade_tx_pkg.sv | 31 +++
 rtl/trade_report_tx_if.sv | 11 +
 rtl/trade_sync_fifo.sv | 66 ++++++
 rtl/trade_report_tx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/trade_tx_pkg.sv
// Shared encodings and sizes for the trade report transmitter.
// Defining TRADE_TX_TIMESTAMP_EN widens the frame header with a 32-bit timestamp.
package trade_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD
  } state_e;

`ifdef TRADE_TX_TIMESTAMP_EN
  localparam int HDR_BYTES = 7;
`else
  localparam int HDR_BYTES = 3;
`endif
  localparam int TRADE_BYTES = 4;
  localparam int SEQ_W       = 16;

  // Byte idx of a trade word, big-endian (idx 0 is the MSB).
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trade_report_tx_if.sv
// 8-bit AXI-Stream link from the trade report transmitter to the UDP TX stack.
// Unaffected by TRADE_TX_TIMESTAMP_EN.
interface trade_report_tx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/trade_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and a peek at the second entry.
// Unaffected by TRADE_TX_TIMESTAMP_EN.
module trade_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] rd_next,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nx;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign push      = wr_en && !full;
  assign pop       = rd_en && !empty;
  assign rd_ptr_nx = rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_nx;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // The transmitter needs the following word on the same edge the head is popped.
  assign rd_data = mem_q[rd_ptr_q];
  assign rd_next = mem_q[rd_ptr_nx];
  assign count   = count_q;

endmodule

// File: rtl/trade_report_tx.sv
// Batches order-book trade words into sequence-numbered frames on an 8-bit AXI-Stream.
// Defining TRADE_TX_TIMESTAMP_EN adds a free-running cycle timestamp to each frame header.
module trade_report_tx
  import trade_tx_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_BATCH     = 8,
  parameter int FLUSH_TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  trade_valid,
  input  logic [31:0]           trade_info,
  trade_report_tx_if.master     m_axis,
  output logic                  tx_busy,
  output logic [15:0]           drop_count,
  output logic [SEQ_W-1:0]      seq_num
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT = TW'(FLUSH_TIMEOUT);
  localparam logic [7:0]    MAX_B   = 8'(MAX_BATCH);

  state_e           state_q, state_d;
  logic [7:0]       batch_q, batch_d, word_idx_q, word_idx_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [15:0]      drop_q, drop_d;
  logic [7:0]       tdata_q, tdata_d, hdr_next;
  logic             tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [31:0]      head, head_next;
  logic [CW-1:0]    count;
  logic             full, empty, pop, accept, batch_ready;
`ifdef TRADE_TX_TIMESTAMP_EN
  logic [31:0]      cycle_q, cycle_d, ts_q, ts_d;
`endif

  trade_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (trade_valid),
    .wr_data (trade_info),
    .rd_en   (pop),
    .rd_data (head),
    .rd_next (head_next),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign accept      = tvalid_q && m_axis.tready;
  assign batch_ready = (count >= CW'(MAX_BATCH));

  // Header byte that follows the one currently presented.
  always_comb begin
    hdr_next = 8'h00;
    case (byte_idx_q + 3'd1)
      3'd1:    hdr_next = seq_q[7:0];
      3'd2:    hdr_next = batch_q;
`ifdef TRADE_TX_TIMESTAMP_EN
      3'd3:    hdr_next = ts_q[31:24];
      3'd4:    hdr_next = ts_q[23:16];
      3'd5:    hdr_next = ts_q[15:8];
      3'd6:    hdr_next = ts_q[7:0];
`endif
      default: hdr_next = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    batch_d    = batch_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    timer_d    = timer_q;
    seq_d      = seq_q;
    drop_d     = drop_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    pop        = 1'b0;
`ifdef TRADE_TX_TIMESTAMP_EN
    cycle_d    = cycle_q + 32'd1;
    ts_d       = ts_q;
`endif

    if (trade_valid && full && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;

    // The output registers always hold the byte being offered; each accept loads the next one.
    case (state_q)
      ST_IDLE: begin
        if (batch_ready || (!empty && timer_q == TIMEOUT)) begin
          state_d    = ST_HDR;
          batch_d    = batch_ready ? MAX_B : 8'(count);
          byte_idx_d = 3'd0;
          word_idx_d = 8'd0;
          timer_d    = '0;
          tdata_d    = seq_q[15:8];
          tvalid_d   = 1'b1;
          tlast_d    = 1'b0;
`ifdef TRADE_TX_TIMESTAMP_EN
          ts_d       = cycle_q;
`endif
        end else if (empty) begin
          timer_d = '0;
        end else if (timer_q != TIMEOUT) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_HDR: begin
        if (accept) begin
          if (byte_idx_q == 3'(HDR_BYTES - 1)) begin
            state_d    = ST_PAYLOAD;
            byte_idx_d = 3'd0;
            tdata_d    = word_byte(head, 2'd0);
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            tdata_d    = hdr_next;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          if (byte_idx_q == 3'(TRADE_BYTES - 1)) begin
            pop = 1'b1;
            if (tlast_q) begin
              state_d  = ST_IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tdata_d  = 8'h00;
              seq_d    = seq_q + 1'b1;
            end else begin
              word_idx_d = word_idx_q + 8'd1;
              byte_idx_d = 3'd0;
              tdata_d    = word_byte(head_next, 2'd0);
            end
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            tdata_d    = word_byte(head, 2'(byte_idx_q + 3'd1));
            tlast_d    = (byte_idx_q == 3'd2) && (word_idx_q == batch_q - 8'd1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      batch_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      timer_q    <= '0;
      seq_q      <= '0;
      drop_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
`ifdef TRADE_TX_TIMESTAMP_EN
      cycle_q    <= '0;
      ts_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      batch_q    <= batch_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      timer_q    <= timer_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
`ifdef TRADE_TX_TIMESTAMP_EN
      cycle_q    <= cycle_d;
      ts_q       <= ts_d;
`endif
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign tx_busy       = (state_q != ST_IDLE);
  assign drop_count    = drop_q;
  assign seq_num       = seq_q;

endmodule
